// File: rtl/sum_n_pkg.sv
// sum_n_pkg: shared types and helpers for the sum-of-N initiator.
//   - state_e      : sequencer states
//   - N_W_DEF/S_W_DEF : default operand and result widths
//   - expected_sum : reference triangle number n*(n+1)/2, with the product
//                    kept to s_w+1 bits and the result truncated to s_w bits
package sum_n_pkg;

    localparam int N_W_DEF = 3;
    localparam int S_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        ACK  = 3'd3,
        FIN  = 3'd4
    } state_e;

    function automatic logic [31:0] expected_sum(input logic [31:0] n, input int unsigned s_w);
        logic [31:0] mask_prod;
        logic [31:0] mask_sum;
        logic [31:0] prod;
        mask_prod = (32'd1 << (s_w + 32'd1)) - 32'd1;
        mask_sum  = (32'd1 << s_w) - 32'd1;
        prod      = (n * (n + 32'd1)) & mask_prod;
        return (prod >> 1) & mask_sum;
    endfunction

endpackage

// File: rtl/sum_n_watchdog.sv
// sum_n_watchdog: cycle counter guarding the WAIT state.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : zero the count (request accepted, entering WAIT)
//   en_i       : count this cycle (sequencer is in WAIT)
//   tc_o       : high in the cycle whose closing edge brings the count to
//                TIMEOUT_CYC, so the abort lands exactly on that edge
module sum_n_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sum_n_client.sv
// sum_n_client: initiator/self-test for a sum-of-N responder.
// On start (in IDLE or FIN) sweeps N over [max(n_first,1), max(n_last,1)],
// checks every returned sum against n*(n+1)/2, counts mismatches and
// aborts the sweep if the responder stalls longer than TIMEOUT_CYC in WAIT.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : sweep request pulse
//   n_first, n_last   : sweep bounds, sampled with start
//   ready, sum_valid, sum : responder status / result
//   N_valid, N_in     : request strobe and operand
//   ack               : one-cycle result acknowledge
//   busy, done        : sweep in progress / finished (held)
//   err_cnt           : saturating mismatch count
//   timeout           : sweep aborted by watchdog
//   last_sum          : last captured responder result
module sum_n_client
    import sum_n_pkg::*;
#(
    parameter int N_W         = N_W_DEF,
    parameter int S_W         = S_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n_first,
    input  logic [N_W-1:0] n_last,
    input  logic           ready,
    input  logic           sum_valid,
    input  logic [S_W-1:0] sum,
    output logic           N_valid,
    output logic [N_W-1:0] N_in,
    output logic           ack,
    output logic           busy,
    output logic           done,
    output logic [3:0]     err_cnt,
    output logic           timeout,
    output logic [S_W-1:0] last_sum
);

    state_e         state_q, state_d;
    logic [N_W-1:0] n_cur_q, n_cur_d;
    logic [N_W-1:0] n_end_q, n_end_d;
    logic [3:0]     err_cnt_q, err_cnt_d;
    logic           timeout_q, timeout_d;
    logic [S_W-1:0] last_sum_q, last_sum_d;
    logic           n_valid_q, ack_q, busy_q, done_q;

    logic [N_W-1:0] n_first_cl_s;
    logic [N_W-1:0] n_last_cl_s;
    logic [S_W-1:0] exp_sum_s;
    logic           wd_clr_s;
    logic           wd_tc_s;

    // N = 0 would wrap the responder's counter, so both bounds floor at 1.
    assign n_first_cl_s = (n_first == {N_W{1'b0}}) ? N_W'(1) : n_first;
    assign n_last_cl_s  = (n_last  == {N_W{1'b0}}) ? N_W'(1) : n_last;
    assign exp_sum_s    = S_W'(expected_sum(32'(n_cur_q), S_W));

    sum_n_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr_i (wd_clr_s),
        .en_i  (state_q == WAIT),
        .tc_o  (wd_tc_s)
    );

    // Next-state and datapath updates for the sweep sequencer.
    always_comb begin
        state_d    = state_q;
        n_cur_d    = n_cur_q;
        n_end_d    = n_end_q;
        err_cnt_d  = err_cnt_q;
        timeout_d  = timeout_q;
        last_sum_d = last_sum_q;
        wd_clr_s   = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    n_cur_d   = n_first_cl_s;
                    // An inverted range collapses to a single request.
                    n_end_d   = (n_last_cl_s < n_first_cl_s) ? n_first_cl_s : n_last_cl_s;
                    err_cnt_d = 4'd0;
                    timeout_d = 1'b0;
                    state_d   = REQ;
                end else begin
                    state_d = state_q;
                end
            end
            REQ: begin
                if (ready) begin
                    wd_clr_s = 1'b1;
                    state_d  = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                // A result arriving on the terminal cycle still counts.
                if (sum_valid) begin
                    last_sum_d = sum;
                    if ((sum != exp_sum_s) && (err_cnt_q != 4'd15)) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    state_d = ACK;
                end else if (wd_tc_s) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    state_d = WAIT;
                end
            end
            ACK: begin
                if (n_cur_q == n_end_q) begin
                    state_d = FIN;
                end else begin
                    n_cur_d = n_cur_q + N_W'(1);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; strobes are decoded from the
    // next state so they are valid for the whole cycle of that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            n_cur_q    <= {N_W{1'b0}};
            n_end_q    <= {N_W{1'b0}};
            err_cnt_q  <= 4'd0;
            timeout_q  <= 1'b0;
            last_sum_q <= {S_W{1'b0}};
            n_valid_q  <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_cur_q    <= n_cur_d;
            n_end_q    <= n_end_d;
            err_cnt_q  <= err_cnt_d;
            timeout_q  <= timeout_d;
            last_sum_q <= last_sum_d;
            n_valid_q  <= (state_d == REQ);
            ack_q      <= (state_d == ACK);
            busy_q     <= (state_d == REQ) || (state_d == WAIT) || (state_d == ACK);
            done_q     <= (state_d == FIN);
        end
    end

    assign N_valid  = n_valid_q;
    assign N_in     = n_cur_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_cnt_q;
    assign timeout  = timeout_q;
    assign last_sum = last_sum_q;

endmodule

// File: tb/tb_sum_n_client.sv
// Testbench for sum_n_client: a behavioural responder (with fault, hang and
// ready hold-off knobs) plus a sweep-level reference model of the results.
module tb_sum_n_client;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] n_first;
    logic [2:0] n_last;
    logic       ready;
    logic       sum_valid;
    logic [4:0] sum;
    logic       N_valid;
    logic [2:0] N_in;
    logic       ack;
    logic       busy;
    logic       done;
    logic [3:0] err_cnt;
    logic       timeout;
    logic [4:0] last_sum;

    int tests = 0;
    int fails = 0;

    // responder configuration
    logic [7:0] cfg_mask = 8'h00;
    int         cfg_hang = 0;
    int         cfg_hold = 0;

    // responder state and monitor observations
    bit r_busy   = 1'b0;
    int r_k      = 0;
    int r_n      = 0;
    int r_wait   = 0;
    int req_q[$];
    int ack_cnt    = 0;
    int ack_multi  = 0;
    int stable_err = 0;
    bit ack_prev   = 1'b0;
    bit nv_prev    = 1'b0;
    int nin_prev   = 0;

    // expected values carried across sweeps
    int exp_last = 0;

    sum_n_client #(
        .N_W         (3),
        .S_W         (5),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_first   (n_first),
        .n_last    (n_last),
        .ready     (ready),
        .sum_valid (sum_valid),
        .sum       (sum),
        .N_valid   (N_valid),
        .N_in      (N_in),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .timeout   (timeout),
        .last_sum  (last_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder and handshake monitor, updated mid-cycle so the DUT sees
    // stable inputs at each rising edge.
    always @(negedge clk) begin
        if (reset) begin
            ready     = 1'b1;
            sum_valid = 1'b0;
            sum       = 5'd0;
            r_busy    = 1'b0;
            r_k       = 0;
            r_wait    = 0;
            ack_prev  = 1'b0;
            nv_prev   = 1'b0;
        end else begin
            if (ack) ack_cnt++;
            if (ack && ack_prev) ack_multi++;
            if (N_valid && nv_prev && (int'(N_in) != nin_prev)) stable_err++;
            ack_prev = ack;
            nv_prev  = N_valid;
            nin_prev = int'(N_in);
            if (r_busy) begin
                r_k++;
                if (r_k == 1) ready = 1'b0;
                if ((r_k == r_n + 1) && (r_n != cfg_hang)) begin
                    sum_valid = 1'b1;
                    sum       = cfg_mask[r_n] ? 5'd0 : 5'(r_n * (r_n + 1) / 2);
                    r_busy    = 1'b0;
                end
            end else if (sum_valid) begin
                if (ack) begin
                    sum_valid = 1'b0;
                    r_wait    = cfg_hold + 1;
                end
            end else begin
                if (r_wait > 0) begin
                    r_wait--;
                    if (r_wait == 0) ready = 1'b1;
                end
                if (ready && N_valid) begin
                    req_q.push_back(int'(N_in));
                    r_busy = 1'b1;
                    r_n    = int'(N_in);
                    r_k    = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, 32'({N_valid, N_in, ack, busy, done, err_cnt, timeout, last_sum}), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outputs_zero(tag);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_last = 0;
        repeat (2) @(negedge clk);
    endtask

    // One sweep: reference model first, then stimulus, then result checks.
    task automatic run_sweep(input string tag, input int nf, input int nl,
                             input logic [7:0] mask, input int hang,
                             input int hold, input int poke);
        int a, b, exp_cyc, exp_err, exp_to, acked, cyc, retv;
        bit got;
        int exp_q[$];
        a = (nf == 0) ? 1 : nf;
        b = (nl == 0) ? 1 : nl;
        if (b < a) b = a;
        exp_cyc = 1;
        exp_err = 0;
        exp_to  = 0;
        acked   = 0;
        for (int n = a; n <= b; n++) begin
            exp_q.push_back(n);
            if (n > a) exp_cyc += hold;
            if (n == hang) begin
                exp_to = 1;
                exp_cyc += 1 + 64;
                break;
            end
            exp_cyc += n + 3;
            acked++;
            retv = mask[n] ? 0 : (n * (n + 1) / 2);
            if (retv != n * (n + 1) / 2) exp_err++;
            exp_last = retv;
        end
        if (exp_err > 15) exp_err = 15;

        repeat (15) @(negedge clk);
        cfg_mask = mask;
        cfg_hang = hang;
        cfg_hold = hold;
        req_q.delete();
        ack_cnt    = 0;
        ack_multi  = 0;
        stable_err = 0;
        @(negedge clk);
        n_first = 3'(nf);
        n_last  = 3'(nl);
        start   = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == poke) begin
                start   = 1'b1;
                n_first = 3'd6;
                n_last  = 3'd6;
            end else begin
                start   = 1'b0;
                n_first = 3'(nf);
                n_last  = 3'(nl);
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, ".cycles"},   32'(cyc), 32'(exp_cyc));
        chk({tag, ".done"},     32'(done), 32'd1);
        chk({tag, ".busy"},     32'(busy), 32'd0);
        chk({tag, ".timeout"},  32'(timeout), 32'(exp_to));
        chk({tag, ".err_cnt"},  32'(err_cnt), 32'(exp_err));
        chk({tag, ".last_sum"}, 32'(last_sum), 32'(exp_last));
        chk({tag, ".n_req"},    32'(req_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s.req%0d", tag, i),
                32'((i < req_q.size()) ? req_q[i] : -1), 32'(exp_q[i]));
        end
        chk({tag, ".acks"},       32'(ack_cnt), 32'(acked));
        chk({tag, ".ack_width"},  32'(ack_multi), 32'd0);
        chk({tag, ".nin_stable"}, 32'(stable_err), 32'd0);
    endtask

    initial begin
        int found;
        int nf, nl, hang, hold;
        logic [7:0] mask;
        reset   = 1'b1;
        start   = 1'b0;
        n_first = 3'd0;
        n_last  = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep("full_1_7", 1, 7, 8'h00, 0, 0, 0);
        run_sweep("degen_0_0", 0, 0, 8'h00, 0, 0, 0);
        run_sweep("degen_5_2", 5, 2, 8'h00, 0, 0, 0);
        run_sweep("faults_3_6", 1, 7, 8'b0100_1000, 0, 0, 0);
        run_sweep("hang_4", 1, 7, 8'h00, 4, 0, 0);
        do_reset("reset_after_hang");
        run_sweep("stress_hold", 1, 7, 8'h00, 0, 10, 10);

        // reset while waiting for the N=5 result
        repeat (15) @(negedge clk);
        cfg_mask = 8'h00;
        cfg_hang = 0;
        cfg_hold = 0;
        n_first = 3'd1;
        n_last  = 3'd7;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 500 && found == 0; k++) begin
            @(negedge clk);
            #1;
            if (busy && !N_valid && !ack && N_in == 3'd5) found = 1;
        end
        chk("midreset.found_wait5", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("midreset.outputs");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_last = 0;
        run_sweep("after_reset_1_2", 1, 2, 8'h00, 0, 0, 0);

        for (int t = 0; t < 12; t++) begin
            nf   = int'($urandom_range(7, 0));
            nl   = int'($urandom_range(7, 0));
            mask = 8'($urandom);
            hang = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
            hold = int'($urandom_range(3, 0));
            run_sweep($sformatf("rand%0d", t), nf, nl, mask, hang, hold, 0);
            if (hang != 0) do_reset($sformatf("rand%0d.reset", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
